blur_line_ctrl: RTL and testbench
=================================

# blur_line_ctrl

Frame/line sequencer that feeds the 3x3 blur scaler. It captures per-frame mode and weight configuration at vsync, generates the vertical line-state code and horizontal pixel count the scaler decodes, and rotates three single-port line SRAM banks. It also emits one internally timed flush line so the last image row is filtered. Sits between the video input timing and the scaler/SRAM complex.

## Interface
- PARAM_WIDTH, 11, width of counters, line codes and SRAM address
- DATA_WIDTH, 8, pixel width
- WEIGHT_WIDTH, 4, per-tap weight width
- H_ACT, 64, active pixels per line (≥3)
- V_ACT, 48, active lines per frame (≥3)

- I_CLK  in  1  clock; the only clock in the block
- I_RSTN  in  1  reset, asynchronous assert, active-low
- i_vsync / i_hsync / i_den  in  1 each  input video timing
- i_data  in  DATA_WIDTH  input pixel, valid with i_den
- i_weight_wr_mode / i_mirror_mode / i_blur_mode  in  1 each  live config
- i_weights  in  9*WEIGHT_WIDTH  live taps, w1 in MSBs
- o_weight_wr_mode_cap / o_mirror_mode_cap / o_blur_mode_cap  out  1 each  captured config
- o_weights_cap  out  9*WEIGHT_WIDTH  captured taps
- o_vsync / o_hsync / o_den  out  1 each  sequenced timing to scaler
- o_vact_state  out  PARAM_WIDTH  line code: 0 idle, 3 first, 5 middle, 7 last
- o_hor_cnt  out  PARAM_WIDTH  pixel index 1..H_ACT while o_den, else 0
- o_sram_we  out  3  one-hot bank write enable
- o_sram_addr  out  PARAM_WIDTH  shared read/write address
- o_sram_wdata  out  DATA_WIDTH  write data
- o_top_bank / o_mid_bank  out  2 each  bank index for rows n-1 and n; row n+1 is write-through data

## Operation
- Reset: every output 0; state S_IDLE; banks wr=0, mid=2, top=1.
- vsync rise: detected as i_vsync & !vsync_q. Always forces S_FILL, line count 0, wr bank 0, from any state, including mid-line (abort current line, o_den drops next cycle).
- FSM:
  - S_IDLE: waits for vsync rise.
  - S_FILL: line 0 is written; no o_den. End of den (fall) -> S_RUN.
  - S_RUN: each input line k (1..V_ACT-1) is written while processed line k-1 is output. After the fall of line V_ACT-1 -> S_FLUSH.
  - S_FLUSH: on the next i_hsync rise, an internal den runs for exactly H_ACT cycles, processing line V_ACT-1 with row n+1 forced to 0; at its end -> S_IDLE.
- Line codes: processed line 0 -> 3; lines 1..V_ACT-2 -> 5; line V_ACT-1 -> 7. The code is loaded when o_den rises and is held after o_den falls until the next load or until S_IDLE (then 0).
- Bank rotation at every den fall in S_FILL/S_RUN: top<=mid, mid<=wr, wr<=old top.
- Writes: o_sram_we[wr]=1 for each i_den cycle in S_FILL/S_RUN; o_sram_addr = pixel index-1; o_sram_wdata = i_data.
- o_hor_cnt counts 1..H_ACT and saturates at H_ACT on overlong lines. Extra input lines beyond V_ACT are ignored (no write, no o_den).
- Config capture: all *_cap outputs load from the live inputs on vsync rise only.

## Timing
- All outputs registered; o_den, o_hor_cnt, o_vact_state, o_sram_* lag i_den by 1 cycle in S_RUN.
- o_vsync/o_hsync are i_vsync/i_hsync delayed 1 cycle in every state.
- Flush den starts 1 cycle after the detected i_hsync rise.
- Config capture takes effect on the cycle after vsync rise. If vsync rise coincides with i_den, the pixel is dropped.

## Configuration
- BLUR_CFG_VSYNC_LOCK_EN defined: config is captured at vsync rise only, as above.
- Not defined: *_cap outputs are registered copies of the live inputs every cycle (1-cycle latency); FSM unchanged.

## Test plan
- Reset mid-S_RUN -> all outputs 0 the same cycle; after release, no o_den until a vsync rise plus one fill line.
- H_ACT=4, V_ACT=3 frame -> o_vact_state 3,5,7 on three output lines; o_hor_cnt 1,2,3,4 each; exactly 3 o_den bursts of 4 cycles; third is the flush after an hsync rise.
- Bank rotation over 4 lines -> wr 0,1,2,0; during line 2 write, top=0, mid=1.
- Weights change mid-frame, macro defined -> *_cap unchanged until next vsync rise; macro undefined -> follows 1 cycle later.
- vsync rise during an active line -> o_den low next cycle; state S_FILL; line count 0; wr bank 0.
- Overlong 6-pixel line with H_ACT=4 -> o_hor_cnt holds 4 for pixels 5-6; extra 4th input line produces no write and no o_den.

Source files
------------

// File: rtl/blur_line_ctrl_if.sv
// Video-side bundle of blur_line_ctrl: input timing/pixel/config from the source
// and the sequenced timing, line codes and SRAM controls going to the scaler.
interface blur_line_ctrl_if #(
   parameter int PARAM_WIDTH  = 11,
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 4
);
   logic                      i_vsync;
   logic                      i_hsync;
   logic                      i_den;
   logic [DATA_WIDTH-1:0]     i_data;
   logic                      i_weight_wr_mode;
   logic                      i_mirror_mode;
   logic                      i_blur_mode;
   logic [9*WEIGHT_WIDTH-1:0] i_weights;

   logic                      o_weight_wr_mode_cap;
   logic                      o_mirror_mode_cap;
   logic                      o_blur_mode_cap;
   logic [9*WEIGHT_WIDTH-1:0] o_weights_cap;
   logic                      o_vsync;
   logic                      o_hsync;
   logic                      o_den;
   logic [PARAM_WIDTH-1:0]    o_vact_state;
   logic [PARAM_WIDTH-1:0]    o_hor_cnt;
   logic [2:0]                o_sram_we;
   logic [PARAM_WIDTH-1:0]    o_sram_addr;
   logic [DATA_WIDTH-1:0]     o_sram_wdata;
   logic [1:0]                o_top_bank;
   logic [1:0]                o_mid_bank;

   modport master (
      output i_vsync, i_hsync, i_den, i_data,
      output i_weight_wr_mode, i_mirror_mode, i_blur_mode, i_weights,
      input  o_weight_wr_mode_cap, o_mirror_mode_cap, o_blur_mode_cap, o_weights_cap,
      input  o_vsync, o_hsync, o_den, o_vact_state, o_hor_cnt,
      input  o_sram_we, o_sram_addr, o_sram_wdata, o_top_bank, o_mid_bank
   );

   modport slave (
      input  i_vsync, i_hsync, i_den, i_data,
      input  i_weight_wr_mode, i_mirror_mode, i_blur_mode, i_weights,
      output o_weight_wr_mode_cap, o_mirror_mode_cap, o_blur_mode_cap, o_weights_cap,
      output o_vsync, o_hsync, o_den, o_vact_state, o_hor_cnt,
      output o_sram_we, o_sram_addr, o_sram_wdata, o_top_bank, o_mid_bank
   );
endinterface

// File: rtl/blur_line_ctrl.sv
// Frame/line sequencer for the 3x3 blur scaler: line codes, pixel count, 3-bank SRAM rotation, flush line.
// Define BLUR_CFG_VSYNC_LOCK_EN to capture config only at vsync rise; otherwise config is re-registered every cycle.
module blur_line_ctrl #(
   parameter int PARAM_WIDTH  = 11,
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 4,
   parameter int H_ACT        = 64,
   parameter int V_ACT        = 48
) (
   input  logic            I_CLK,
   input  logic            I_RSTN,
   blur_line_ctrl_if.slave bus
);
   localparam int PW = PARAM_WIDTH;
   localparam logic [PW-1:0] H_LAST     = PW'(H_ACT);
   localparam logic [PW-1:0] V_LAST     = PW'(V_ACT - 1);
   localparam logic [PW-1:0] CODE_FIRST = PW'(3);
   localparam logic [PW-1:0] CODE_MID   = PW'(5);
   localparam logic [PW-1:0] CODE_LAST  = PW'(7);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

   state_t                    state_reg;
   logic                      vsync_q_reg;
   logic                      hsync_q_reg;
   logic                      den_q_reg;
   logic [PW-1:0]             line_reg;
   logic [PW-1:0]             pix_reg;
   logic                      flush_reg;
   logic [1:0]                wr_bank_reg;
   logic [1:0]                mid_bank_reg;
   logic [1:0]                top_bank_reg;

   logic                      vsync_out_reg;
   logic                      hsync_out_reg;
   logic                      den_reg;
   logic [PW-1:0]             hor_reg;
   logic [PW-1:0]             vact_reg;
   logic [2:0]                we_reg;
   logic [PW-1:0]             addr_reg;
   logic [DATA_WIDTH-1:0]     wdata_reg;
   logic [1:0]                top_out_reg;
   logic [1:0]                mid_out_reg;
   logic                      wr_mode_cap_reg;
   logic                      mirror_cap_reg;
   logic                      blur_cap_reg;
   logic [9*WEIGHT_WIDTH-1:0] weights_cap_reg;

   logic          vsync_rise;
   logic          hsync_rise;
   logic          den_fall;
   logic          wr_en;
   logic [PW-1:0] pix_next;
   logic [2:0]    wr_onehot;

   assign vsync_rise = bus.i_vsync & ~vsync_q_reg;
   assign hsync_rise = bus.i_hsync & ~hsync_q_reg;
   assign den_fall   = den_q_reg & ~bus.i_den;
   // A pixel coinciding with the vsync rise is dropped.
   assign wr_en      = bus.i_den & ~vsync_rise &
                       ((state_reg == S_FILL) || (state_reg == S_RUN));
   assign pix_next   = (pix_reg == H_LAST) ? H_LAST : pix_reg + PW'(1);

   for (genvar gi = 0; gi < 3; gi++) begin : g_we
      assign wr_onehot[gi] = (wr_bank_reg == 2'(gi));
   end

   always_ff @(posedge I_CLK or negedge I_RSTN) begin
      if (!I_RSTN) begin
         state_reg       <= S_IDLE;
         vsync_q_reg     <= 1'b0;
         hsync_q_reg     <= 1'b0;
         den_q_reg       <= 1'b0;
         line_reg        <= '0;
         pix_reg         <= '0;
         flush_reg       <= 1'b0;
         wr_bank_reg     <= 2'd0;
         mid_bank_reg    <= 2'd2;
         top_bank_reg    <= 2'd1;
         vsync_out_reg   <= 1'b0;
         hsync_out_reg   <= 1'b0;
         den_reg         <= 1'b0;
         hor_reg         <= '0;
         vact_reg        <= '0;
         we_reg          <= '0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         top_out_reg     <= 2'd0;
         mid_out_reg     <= 2'd0;
         wr_mode_cap_reg <= 1'b0;
         mirror_cap_reg  <= 1'b0;
         blur_cap_reg    <= 1'b0;
         weights_cap_reg <= '0;
      end else begin
         vsync_q_reg   <= bus.i_vsync;
         hsync_q_reg   <= bus.i_hsync;
         den_q_reg     <= bus.i_den;
         vsync_out_reg <= bus.i_vsync;
         hsync_out_reg <= bus.i_hsync;
         // Bank outputs are registered copies so every output reads 0 while in reset.
         top_out_reg   <= top_bank_reg;
         mid_out_reg   <= mid_bank_reg;

         den_reg   <= 1'b0;
         hor_reg   <= '0;
         addr_reg  <= '0;
         we_reg    <= '0;
         wdata_reg <= '0;
         pix_reg   <= bus.i_den ? pix_next : '0;

`ifdef BLUR_CFG_VSYNC_LOCK_EN
         if (vsync_rise) begin
            wr_mode_cap_reg <= bus.i_weight_wr_mode;
            mirror_cap_reg  <= bus.i_mirror_mode;
            blur_cap_reg    <= bus.i_blur_mode;
            weights_cap_reg <= bus.i_weights;
         end
`else
         wr_mode_cap_reg <= bus.i_weight_wr_mode;
         mirror_cap_reg  <= bus.i_mirror_mode;
         blur_cap_reg    <= bus.i_blur_mode;
         weights_cap_reg <= bus.i_weights;
`endif

         if (vsync_rise) begin
            state_reg    <= S_FILL;
            line_reg     <= '0;
            pix_reg      <= '0;
            flush_reg    <= 1'b0;
            wr_bank_reg  <= 2'd0;
            mid_bank_reg <= 2'd2;
            top_bank_reg <= 2'd1;
         end else begin
            if (wr_en) begin
               we_reg    <= wr_onehot;
               addr_reg  <= pix_next - PW'(1);
               wdata_reg <= bus.i_data;
            end
            case (state_reg)
               S_IDLE: ;
               S_FILL: begin
                  if (den_fall) begin
                     top_bank_reg <= mid_bank_reg;
                     mid_bank_reg <= wr_bank_reg;
                     wr_bank_reg  <= top_bank_reg;
                     line_reg     <= PW'(1);
                     state_reg    <= S_RUN;
                  end
               end
               S_RUN: begin
                  // Input line k is written while processed line k-1 is output.
                  if (wr_en) begin
                     den_reg <= 1'b1;
                     hor_reg <= pix_next;
                     if (!den_reg)
                        vact_reg <= (line_reg == PW'(1)) ? CODE_FIRST : CODE_MID;
                  end
                  if (den_fall) begin
                     top_bank_reg <= mid_bank_reg;
                     mid_bank_reg <= wr_bank_reg;
                     wr_bank_reg  <= top_bank_reg;
                     if (line_reg == V_LAST)
                        state_reg <= S_FLUSH;
                     else
                        line_reg <= line_reg + PW'(1);
                  end
               end
               S_FLUSH: begin
                  // Row n+1 is absent here, so write data stays 0 for the whole flush line.
                  if (flush_reg) begin
                     if (hor_reg == H_LAST) begin
                        flush_reg <= 1'b0;
                        vact_reg  <= '0;
                        state_reg <= S_IDLE;
                     end else begin
                        den_reg  <= 1'b1;
                        hor_reg  <= hor_reg + PW'(1);
                        addr_reg <= hor_reg;
                     end
                  end else if (hsync_rise) begin
                     flush_reg <= 1'b1;
                     den_reg   <= 1'b1;
                     hor_reg   <= PW'(1);
                     addr_reg  <= '0;
                     vact_reg  <= CODE_LAST;
                  end
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.o_vsync              = vsync_out_reg;
   assign bus.o_hsync              = hsync_out_reg;
   assign bus.o_den                = den_reg;
   assign bus.o_hor_cnt            = hor_reg;
   assign bus.o_vact_state         = vact_reg;
   assign bus.o_sram_we            = we_reg;
   assign bus.o_sram_addr          = addr_reg;
   assign bus.o_sram_wdata         = wdata_reg;
   assign bus.o_top_bank           = top_out_reg;
   assign bus.o_mid_bank           = mid_out_reg;
   assign bus.o_weight_wr_mode_cap = wr_mode_cap_reg;
   assign bus.o_mirror_mode_cap    = mirror_cap_reg;
   assign bus.o_blur_mode_cap      = blur_cap_reg;
   assign bus.o_weights_cap        = weights_cap_reg;
endmodule

// File: tb/tb_blur_line_ctrl.sv
// Bench for blur_line_ctrl with H_ACT=4, V_ACT=3: cycle table over two frames plus
// hand sequences for config capture and reset in the middle of a running line.
module tb_blur_line_ctrl;
   localparam int PW = 11;
   localparam int DW = 8;
   localparam int WW = 4;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   typedef struct {
      logic           v;
      logic           h;
      logic           d;
      logic [DW-1:0]  data;
      logic           eden;
      logic [PW-1:0]  ehor;
      logic [PW-1:0]  evact;
      logic [2:0]     ewe;
      logic [PW-1:0]  eaddr;
      logic [1:0]     etop;
      logic [1:0]     emid;
   } vec_t;

   vec_t vecs[$];

   blur_line_ctrl_if #(.PARAM_WIDTH(PW), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) bus_if ();

   blur_line_ctrl #(
      .PARAM_WIDTH(PW), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .H_ACT(4), .V_ACT(3)
   ) dut (
      .I_CLK (clk),
      .I_RSTN(rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input int v, input int h, input int d, input int data,
                      input int eden, input int ehor, input int evact, input int ewe,
                      input int eaddr, input int etop, input int emid);
      vec_t r;
      r.v = v[0]; r.h = h[0]; r.d = d[0]; r.data = data[DW-1:0];
      r.eden = eden[0]; r.ehor = ehor[PW-1:0]; r.evact = evact[PW-1:0];
      r.ewe = ewe[2:0]; r.eaddr = eaddr[PW-1:0]; r.etop = etop[1:0]; r.emid = emid[1:0];
      vecs.push_back(r);
   endtask

   task automatic drive(input logic v, input logic h, input logic d, input logic [DW-1:0] data);
      bus_if.i_vsync = v;
      bus_if.i_hsync = h;
      bus_if.i_den   = d;
      bus_if.i_data  = data;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else
         $display("[TB] ok %s = %0h", name, act);
   endtask

   function automatic logic [127:0] all_out();
      return {bus_if.o_vsync, bus_if.o_hsync, bus_if.o_den, bus_if.o_hor_cnt,
              bus_if.o_vact_state, bus_if.o_sram_we, bus_if.o_sram_addr,
              bus_if.o_sram_wdata, bus_if.o_top_bank, bus_if.o_mid_bank,
              bus_if.o_weight_wr_mode_cap, bus_if.o_mirror_mode_cap,
              bus_if.o_blur_mode_cap, bus_if.o_weights_cap};
   endfunction

   function automatic logic [38:0] caps();
      return {bus_if.o_weight_wr_mode_cap, bus_if.o_mirror_mode_cap,
              bus_if.o_blur_mode_cap, bus_if.o_weights_cap};
   endfunction

   task automatic check_row(input int idx);
      vec_t r;
      logic [DW-1:0] ewd;
      r = vecs[idx];
      ewd = (r.ewe != 3'b000) ? r.data : '0;
      tests++;
      if (bus_if.o_vsync !== r.v || bus_if.o_hsync !== r.h || bus_if.o_den !== r.eden ||
          bus_if.o_hor_cnt !== r.ehor || bus_if.o_vact_state !== r.evact ||
          bus_if.o_sram_we !== r.ewe || bus_if.o_sram_addr !== r.eaddr ||
          bus_if.o_sram_wdata !== ewd || bus_if.o_top_bank !== r.etop ||
          bus_if.o_mid_bank !== r.emid) begin
         fails++;
         $display("FAIL row%0d: got vs=%0d hs=%0d den=%0d hor=%0d vact=%0d we=%b addr=%0d wd=%h top=%0d mid=%0d; expected vs=%0d hs=%0d den=%0d hor=%0d vact=%0d we=%b addr=%0d wd=%h top=%0d mid=%0d",
                  idx, bus_if.o_vsync, bus_if.o_hsync, bus_if.o_den, bus_if.o_hor_cnt,
                  bus_if.o_vact_state, bus_if.o_sram_we, bus_if.o_sram_addr,
                  bus_if.o_sram_wdata, bus_if.o_top_bank, bus_if.o_mid_bank,
                  r.v, r.h, r.eden, r.ehor, r.evact, r.ewe, r.eaddr, ewd, r.etop, r.emid);
      end else
         $display("[TB] row%0d ok den=%0d hor=%0d vact=%0d we=%b", idx,
                  bus_if.o_den, bus_if.o_hor_cnt, bus_if.o_vact_state, bus_if.o_sram_we);
   endtask

   // One input line of npx pixels followed by 3 idle cycles; counts o_den and write cycles.
   task automatic run_line(input int npx, output int den_cnt, output int we_cnt);
      den_cnt = 0;
      we_cnt  = 0;
      for (int i = 0; i < npx + 3; i++) begin
         drive(1'b0, 1'b0, (i < npx) ? 1'b1 : 1'b0, DW'(i));
         @(negedge clk);
         if (bus_if.o_den) den_cnt++;
         if (bus_if.o_sram_we != 3'b000) we_cnt++;
      end
   endtask

   initial begin
      logic [38:0] cap_a;
      logic [38:0] cap_b;
      logic [38:0] cap_c;
      int          dc;
      int          wc;

      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0);
      bus_if.i_weight_wr_mode = 1'b0;
      bus_if.i_mirror_mode    = 1'b0;
      bus_if.i_blur_mode      = 1'b0;
      bus_if.i_weights        = '0;

      // Frame 1: fill, two run lines, flush, then an extra ignored input line.
      add(0,0,0,0,    0,0,0,0,0,1,2);
      add(1,0,0,0,    0,0,0,0,0,1,2);
      add(0,0,0,0,    0,0,0,0,0,1,2);
      add(0,1,0,0,    0,0,0,0,0,1,2);
      add(0,0,0,0,    0,0,0,0,0,1,2);
      for (int i = 0; i < 4; i++) add(0,0,1,'hA0+i, 0,0,0,1,i,1,2);
      add(0,0,0,0,    0,0,0,0,0,1,2);
      add(0,1,0,0,    0,0,0,0,0,2,0);
      add(0,0,0,0,    0,0,0,0,0,2,0);
      for (int i = 0; i < 4; i++) add(0,0,1,'hB0+i, 1,i+1,3,2,i,2,0);
      add(0,0,0,0,    0,0,3,0,0,2,0);
      add(0,1,0,0,    0,0,3,0,0,0,1);
      add(0,0,0,0,    0,0,3,0,0,0,1);
      for (int i = 0; i < 4; i++) add(0,0,1,'hC0+i, 1,i+1,5,4,i,0,1);
      add(0,0,0,0,    0,0,5,0,0,0,1);
      add(0,0,0,0,    0,0,5,0,0,1,2);
      add(0,1,0,0,    1,1,7,0,0,1,2);
      for (int i = 1; i < 4; i++) add(0,0,0,0, 1,i+1,7,0,i,1,2);
      add(0,0,0,0,    0,0,0,0,0,1,2);
      add(0,1,0,0,    0,0,0,0,0,1,2);
      add(0,0,0,0,    0,0,0,0,0,1,2);
      for (int i = 0; i < 4; i++) add(0,0,1,'hD0+i, 0,0,0,0,0,1,2);
      add(0,0,0,0,    0,0,0,0,0,1,2);
      // Frame 2: overlong 6-pixel line, then vsync rise in the middle of an active line.
      add(1,0,0,0,    0,0,0,0,0,1,2);
      add(0,0,0,0,    0,0,0,0,0,1,2);
      for (int i = 0; i < 4; i++) add(0,0,1,'hE0+i, 0,0,0,1,i,1,2);
      add(0,0,0,0,    0,0,0,0,0,1,2);
      add(0,0,0,0,    0,0,0,0,0,2,0);
      for (int i = 0; i < 6; i++) add(0,0,1,'hF0+i, 1,(i<4)?i+1:4,3,2,(i<4)?i:3,2,0);
      add(0,0,0,0,    0,0,3,0,0,2,0);
      add(0,0,0,0,    0,0,3,0,0,0,1);
      for (int i = 0; i < 2; i++) add(0,0,1,'h10+i, 1,i+1,5,4,i,0,1);
      add(1,0,1,'h12, 0,0,5,0,0,0,1);
      add(1,0,1,'h13, 0,0,5,1,0,1,2);
      add(0,0,0,0,    0,0,5,0,0,1,2);
      add(0,0,0,0,    0,0,5,0,0,2,0);

      repeat (3) @(negedge clk);
      chk("reset_outputs_zero", all_out(), '0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].v, vecs[i].h, vecs[i].d, vecs[i].data);
         @(negedge clk);
         check_row(i);
      end

      // Config capture.
      cap_a = {1'b1, 1'b0, 1'b1, 36'h123456789};
      cap_b = {1'b0, 1'b1, 1'b0, 36'hFEDCBA987};
      cap_c = {1'b1, 1'b1, 1'b1, 36'h0F0F0F0F0};
      {bus_if.i_weight_wr_mode, bus_if.i_mirror_mode, bus_if.i_blur_mode, bus_if.i_weights} = cap_a;
      drive(1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      chk("cap_at_vsync_a", {25'd0, caps()}, {25'd0, cap_a});
      drive(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      {bus_if.i_weight_wr_mode, bus_if.i_mirror_mode, bus_if.i_blur_mode, bus_if.i_weights} = cap_b;
      #1;
      chk("cap_registered", {25'd0, caps()}, {25'd0, cap_a});
      @(negedge clk);
`ifdef BLUR_CFG_VSYNC_LOCK_EN
      chk("cap_midframe_1", {25'd0, caps()}, {25'd0, cap_a});
`else
      chk("cap_midframe_1", {25'd0, caps()}, {25'd0, cap_b});
`endif
      repeat (3) @(negedge clk);
`ifdef BLUR_CFG_VSYNC_LOCK_EN
      chk("cap_midframe_4", {25'd0, caps()}, {25'd0, cap_a});
`else
      chk("cap_midframe_4", {25'd0, caps()}, {25'd0, cap_b});
`endif
      {bus_if.i_weight_wr_mode, bus_if.i_mirror_mode, bus_if.i_blur_mode, bus_if.i_weights} = cap_c;
      drive(1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      chk("cap_at_vsync_c", {25'd0, caps()}, {25'd0, cap_c});
      drive(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);

      // Reset while a run line is being output.
      run_line(4, dc, wc);
      chk("pre_fill_den", 128'(dc), 128'd0);
      chk("pre_fill_we", 128'(wc), 128'd4);
      drive(1'b0, 1'b0, 1'b1, 8'h55);
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_den", {127'd0, bus_if.o_den}, 128'd1);
      rst_n = 1'b0;
      #1;
      chk("reset_midrun_zero", all_out(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      run_line(4, dc, wc);
      chk("post_reset_idle_den", 128'(dc), 128'd0);
      chk("post_reset_idle_we", 128'(wc), 128'd0);
      drive(1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      run_line(4, dc, wc);
      chk("post_reset_fill_den", 128'(dc), 128'd0);
      run_line(4, dc, wc);
      chk("post_reset_run_den", 128'(dc), 128'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
